dense_feature_streamer: RTL and testbench
=========================================

Name: dense_feature_streamer

Overview:
- Buffers the flattened 13x13 pooled feature map (169 signed 16-bit values) from the pooling stage.
- Replays the buffer to dense_layer using its start/feature_in protocol: start held high for exactly one cycle, feature 0 presented in that same cycle, features 1..N-1 on the following consecutive cycles.
- Waits for dense_layer done, latches both class scores and reports the winning class.
- Sits between the pooling output and dense_layer in the CNN datapath.

Parameters:
- N_FEATURES, 169, number of features per inference.
- DATA_W, 16, signed feature width.
- SCORE_W, 32, signed class-score width.
- DONE_TIMEOUT, 1024, maximum cycles in WAIT_DONE before an error abort.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  pooling stage presents a feature.
- in_data  input  DATA_W  signed feature from pooling.
- in_ready  output  1  streamer accepts in_data this cycle.
- dense_start  output  1  one-cycle start pulse to dense_layer.
- dense_feature  output  DATA_W  signed feature to dense_layer feature_in.
- dense_done  input  1  dense_layer done.
- class_0_score  input  SCORE_W  dense_layer class 0 score.
- class_1_score  input  SCORE_W  dense_layer class 1 score.
- result_valid  output  1  one-cycle pulse: result fields updated.
- result_class  output  1  winning class index.
- result_score0  output  SCORE_W  latched class 0 score.
- result_score1  output  SCORE_W  latched class 1 score.
- busy  output  1  high in every state except FILL.
- timeout_err  output  1  sticky; set when the done timeout fires.

Behaviour:
- Reset (asynchronous, any state): state = FILL, write and read pointers = 0, timeout counter = 0. All outputs are 0 except in_ready, which is 1 because it is combinational from state. Buffer contents are undefined after reset and are not cleared.
- All outputs are registered except in_ready.
- FILL:
  - in_ready = 1.
  - On in_valid & in_ready, write in_data to buf[wr_ptr] and increment wr_ptr.
  - When the write at wr_ptr = N_FEATURES-1 occurs (cycle T), go to STREAM and reset wr_ptr to 0.
- STREAM:
  - in_ready = 0; in_valid is ignored and no data is lost from the buffer.
  - dense_feature = buf[k] in cycle T+1+k, for k = 0..N_FEATURES-1.
  - dense_start = 1 only in cycle T+1.
  - After the last feature, dense_feature returns to 0 in the next cycle and the state goes to WAIT_DONE.
  - dense_done seen during STREAM is ignored.
- WAIT_DONE:
  - The timeout counter increments each cycle.
  - On dense_done = 1: latch class_0_score and class_1_score into result_score0/1 and set result_class = (class_1_score > class_0_score) as a signed comparison. A tie gives 0. Go to REPORT.
  - If the counter reaches DONE_TIMEOUT before dense_done: set timeout_err = 1, leave the result outputs unchanged, and go to FILL.
  - When dense_done and the timeout occur in the same cycle, dense_done wins.
- REPORT: result_valid = 1 for exactly one cycle, then go to FILL. result fields hold their values until the next REPORT.
- timeout_err is cleared only by reset.
- Throughput: one inference per N_FEATURES fills + N_FEATURES stream cycles + dense latency + 1 cycle.

Test Plan:
- Fill 169 ones with in_valid held high -> in_ready drops after the 169th write. dense_start is high for exactly 1 cycle with dense_feature = 1 in that cycle. dense_feature = 1 for 169 consecutive cycles, then 0.
- Fill ramp 0..168 with random in_valid gaps -> dense_feature emits 0,1,...,168 in order with no gaps. Check against a dense_layer model fed identically.
- Hold in_valid = 1 with in_data = 0x7FFF throughout STREAM/WAIT_DONE -> in_ready = 0, the buffer is unchanged, and the next fill starts only after result_valid.
- dense_done with scores (-5, 7) -> result_class = 1, score0 = -5, score1 = 7, result_valid is a 1-cycle pulse. Scores (100, 100) -> class 0. Scores (0x80000000, -1) -> class 1.
- Never assert dense_done -> timeout_err = 1 exactly DONE_TIMEOUT cycles after entering WAIT_DONE, state returns to FILL, and result_valid is never asserted.
- Assert reset at stream index 50 -> all outputs go to 0 immediately and in_ready = 1. A fresh 169-feature fill then streams correctly from index 0.

Source files
------------

// File: rtl/dense_feature_streamer.sv
// Buffers one flattened pooled feature map and replays it to dense_layer,
// then collects the two class scores and reports the winning class.
module dense_feature_streamer #(
  parameter int N_FEATURES   = 169,
  parameter int DATA_W       = 16,
  parameter int SCORE_W      = 32,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic                      in_ready,
  output logic                      dense_start,
  output logic signed [DATA_W-1:0]  dense_feature,
  input  logic                      dense_done,
  input  logic signed [SCORE_W-1:0] class_0_score,
  input  logic signed [SCORE_W-1:0] class_1_score,
  output logic                      result_valid,
  output logic                      result_class,
  output logic signed [SCORE_W-1:0] result_score0,
  output logic signed [SCORE_W-1:0] result_score1,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int PTR_W = $clog2(N_FEATURES + 1);
  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {FILL, STREAM, WAIT_DONE, REPORT} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  feature_buf [N_FEATURES];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          timeout_cnt;
  logic                      wr_en;

  assign in_ready = (state == FILL);
  assign wr_en    = in_valid && in_ready;

  // Storage is deliberately left without reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      feature_buf[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      timeout_cnt   <= '0;
      dense_start   <= 1'b0;
      dense_feature <= '0;
      result_valid  <= 1'b0;
      result_class  <= 1'b0;
      result_score0 <= '0;
      result_score1 <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      dense_start  <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        FILL: begin
          if (wr_en) begin
            if (wr_ptr == PTR_W'(N_FEATURES - 1)) begin
              // Feature 0 goes out alongside the start pulse; the read pointer
              // therefore begins at 1 in STREAM.
              wr_ptr        <= '0;
              rd_ptr        <= PTR_W'(1);
              state         <= STREAM;
              busy          <= 1'b1;
              dense_start   <= 1'b1;
              dense_feature <= (N_FEATURES == 1) ? in_data : feature_buf[0];
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end
        end
        STREAM: begin
          if (rd_ptr == PTR_W'(N_FEATURES)) begin
            dense_feature <= '0;
            rd_ptr        <= '0;
            state         <= WAIT_DONE;
          end else begin
            dense_feature <= feature_buf[rd_ptr];
            rd_ptr        <= rd_ptr + PTR_W'(1);
          end
        end
        WAIT_DONE: begin
          // A done arriving on the final timeout cycle still counts as success.
          if (dense_done) begin
            result_score0 <= class_0_score;
            result_score1 <= class_1_score;
            result_class  <= (class_1_score > class_0_score);
            result_valid  <= 1'b1;
            timeout_cnt   <= '0;
            state         <= REPORT;
          end else if (timeout_cnt == CNT_W'(DONE_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            timeout_cnt <= '0;
            busy        <= 1'b0;
            state       <= FILL;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= FILL;
        end
        default: begin
          busy  <= 1'b0;
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_feature_streamer.sv
// Directed bench for dense_feature_streamer: scoreboard queue of buffered
// features, a small weighted-sum dense model, and score/timeout/reset cases.
module tb_dense_feature_streamer;

  localparam int N  = 169;
  localparam int DW = 16;
  localparam int SW = 32;
  localparam int TO = 1024;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 dense_start;
  logic signed [DW-1:0] dense_feature;
  logic                 dense_done;
  logic signed [SW-1:0] class_0_score;
  logic signed [SW-1:0] class_1_score;
  logic                 result_valid;
  logic                 result_class;
  logic signed [SW-1:0] result_score0;
  logic signed [SW-1:0] result_score1;
  logic                 busy;
  logic                 timeout_err;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic signed [DW-1:0] expq [$];
  int expAcc;
  int obsAcc;
  int fillIdx;

  dense_feature_streamer #(
    .N_FEATURES(N), .DATA_W(DW), .SCORE_W(SW), .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dense_start(dense_start), .dense_feature(dense_feature),
    .dense_done(dense_done), .class_0_score(class_0_score),
    .class_1_score(class_1_score), .result_valid(result_valid),
    .result_class(result_class), .result_score0(result_score0),
    .result_score1(result_score1), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int wt(input int i);
    return (i % 7) - 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic startFill();
    expAcc  = 0;
    fillIdx = 0;
  endtask

  // Drives one accepted feature after an optional idle gap and records it.
  task automatic applyStimulus(input logic signed [DW-1:0] d, input int gap);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    checkOutput("in_ready_fill", in_ready, 1);
    expq.push_back(d);
    expAcc += int'(d) * wt(fillIdx);
    fillIdx++;
    @(negedge clk);
  endtask

  task automatic checkStream(input logic holdValid, input logic doneNoise, input int stopAt);
    logic signed [DW-1:0] e;
    in_valid   = holdValid;
    in_data    = 16'sh7FFF;
    dense_done = doneNoise;
    obsAcc     = 0;
    for (int k = 0; k < N; k++) begin
      checkOutput("dense_start", dense_start, (k == 0));
      checkOutput("in_ready_stream", in_ready, 0);
      checkOutput("busy_stream", busy, 1);
      e = (expq.size() != 0) ? expq.pop_front() : 'x;
      checkOutput("dense_feature", dense_feature, e);
      obsAcc += int'(dense_feature) * wt(k);
      if (k == stopAt) return;
      @(negedge clk);
    end
    dense_done = 1'b0;
    checkOutput("feature_after_stream", dense_feature, 0);
    checkOutput("start_after_stream", dense_start, 0);
    checkOutput("in_ready_wait", in_ready, 0);
    checkOutput("dense_model_acc", obsAcc, expAcc);
  endtask

  task automatic finishInference(input int waitCycles, input logic signed [SW-1:0] s0,
                                 input logic signed [SW-1:0] s1, input logic expClass);
    repeat (waitCycles) begin
      checkOutput("result_valid_wait", result_valid, 0);
      checkOutput("busy_wait", busy, 1);
      @(negedge clk);
    end
    dense_done    = 1'b1;
    class_0_score = s0;
    class_1_score = s1;
    @(negedge clk);
    dense_done    = 1'b0;
    class_0_score = 32'sd12345;
    class_1_score = -32'sd999;
    checkOutput("result_valid_pulse", result_valid, 1);
    checkOutput("result_class", result_class, expClass);
    checkOutput("result_score0", result_score0, s0);
    checkOutput("result_score1", result_score1, s1);
    checkOutput("busy_report", busy, 1);
    checkOutput("in_ready_report", in_ready, 0);
    @(negedge clk);
    checkOutput("result_valid_drop", result_valid, 0);
    checkOutput("busy_idle", busy, 0);
    checkOutput("in_ready_idle", in_ready, 1);
    checkOutput("result_class_hold", result_class, expClass);
    checkOutput("result_score0_hold", result_score0, s0);
    checkOutput("result_score1_hold", result_score1, s1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_dense_start"}, dense_start, 0);
    checkOutput({tag, "_dense_feature"}, dense_feature, 0);
    checkOutput({tag, "_result_valid"}, result_valid, 0);
    checkOutput({tag, "_result_class"}, result_class, 0);
    checkOutput({tag, "_result_score0"}, result_score0, 0);
    checkOutput({tag, "_result_score1"}, result_score1, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int waited;
    logic sawValid;
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    dense_done    = 1'b0;
    class_0_score = '0;
    class_1_score = '0;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    reset = 1'b0;
    @(negedge clk);
    checkIdle("post_reset");

    $display("[TB] ones frame, scores (-5, 7)");
    startFill();
    for (int i = 0; i < N; i++) applyStimulus(16'sd1, 0);
    checkStream(1'b0, 1'b0, -1);
    finishInference(3, -32'sd5, 32'sd7, 1'b1);

    $display("[TB] ramp frame with gaps, input held during stream, scores (100, 100)");
    startFill();
    for (int i = 0; i < N; i++) applyStimulus(16'(i), int'($urandom_range(0, 2)));
    checkStream(1'b1, 1'b0, -1);
    finishInference(10, 32'sd100, 32'sd100, 1'b0);

    $display("[TB] random frame, done noise during stream, scores (min, -1)");
    startFill();
    applyStimulus(16'sh7FFF, 0);
    for (int i = 1; i < N; i++) applyStimulus(16'($urandom), int'($urandom_range(0, 1)));
    checkStream(1'b0, 1'b1, -1);
    finishInference(0, 32'sh8000_0000, -32'sd1, 1'b1);

    $display("[TB] timeout frame");
    startFill();
    for (int i = 0; i < N; i++) applyStimulus(16'(N - i), 0);
    checkStream(1'b0, 1'b0, -1);
    checkOutput("timeout_err_entry", timeout_err, 0);
    waited   = 0;
    sawValid = 1'b0;
    while (waited < TO + 20 && timeout_err !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (result_valid) sawValid = 1'b1;
    end
    checkOutput("timeout_cycles", waited, TO);
    checkOutput("timeout_err_set", timeout_err, 1);
    checkOutput("timeout_no_result", sawValid, 0);
    checkOutput("timeout_in_ready", in_ready, 1);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_class_hold", result_class, 1);
    checkOutput("timeout_score0_hold", result_score0, 32'sh8000_0000);
    checkOutput("timeout_score1_hold", result_score1, -32'sd1);
    repeat (5) @(negedge clk);
    checkOutput("timeout_err_sticky", timeout_err, 1);

    $display("[TB] reset mid-stream");
    startFill();
    for (int i = 0; i < N; i++) applyStimulus(16'(3 * i - 200), 0);
    checkStream(1'b0, 1'b0, 50);
    reset = 1'b1;
    #1;
    checkIdle("mid_stream_reset");
    @(negedge clk);
    reset = 1'b0;
    expq.delete();
    startFill();
    for (int i = 0; i < N; i++) applyStimulus(16'(i * 7 - 500), int'($urandom_range(0, 1)));
    checkStream(1'b0, 1'b0, -1);
    finishInference(2, 32'sd3, 32'sd2, 1'b0);

    if (failed != 0) $display("[TB] %0d checks did not hold", failed);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
